// File: rtl/dcm_lock_supervisor_pkg.sv
// Shared types and helpers for the DCM lock supervisor: FSM state encoding,
// STATUS bit index and the per-state decode of the registered control outputs.
package dcm_lock_supervisor_pkg;

  typedef enum logic [2:0] {
    RESET_DCM = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  // DCM_SP STATUS[1] reports that CLKIN has stopped toggling
  localparam int CLKIN_STOPPED_BIT = 1;

  typedef struct packed {
    logic dcm_rst;
    logic sys_rst_n;
    logic ready;
    logic fault;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{dcm_rst: 1'b1, sys_rst_n: 1'b0, ready: 1'b0, fault: 1'b0};

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Control outputs held while resident in a state; unknown encodings keep the DCM in reset
  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = CTRL_RESET;
    case (s)
      RESET_DCM: c = CTRL_RESET;
      WAIT_LOCK: c = '{dcm_rst: 1'b0, sys_rst_n: 1'b0, ready: 1'b0, fault: 1'b0};
      STABILIZE: c = '{dcm_rst: 1'b0, sys_rst_n: 1'b0, ready: 1'b0, fault: 1'b0};
      RUN:       c = '{dcm_rst: 1'b0, sys_rst_n: 1'b1, ready: 1'b1, fault: 1'b0};
      FAULT:     c = '{dcm_rst: 1'b1, sys_rst_n: 1'b0, ready: 1'b0, fault: 1'b1};
      default:   c = CTRL_RESET;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, cleared to 0 by rst_n.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // Shift the asynchronous input through two flops to settle metastability
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      q_r    <= 1'b0;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/dcm_lock_supervisor.sv
// DCM_SP reset sequencer: pulses DCM RST, waits for LOCKED with a timeout and a
// bounded retry count, releases the downstream reset once lock has been stable,
// and re-arms the DCM whenever lock is lost or CLKIN stops.
module dcm_lock_supervisor
  import dcm_lock_supervisor_pkg::*;
#(
  parameter int RST_CYCLES    = 3,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       dcm_locked,
  input  logic [7:0] dcm_status,
  input  logic       restart,
  output logic       dcm_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt
);

  localparam int CNT_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LAST   = 4'(MAX_RETRIES - 1);
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

  logic             locked_s;
  logic             stop_s;
  logic             lock_lost_s;
  logic             status_unused;
  state_t           state_r;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       retry_r;
  logic [3:0]       retry_nxt;
  logic [3:0]       retry_inc;
  ctrl_t            ctrl_r;

  sync_2ff u_sync_locked (
    .clk   (clk_in),
    .rst_n (rst_n),
    .d     (dcm_locked),
    .q     (locked_s)
  );

  sync_2ff u_sync_stop (
    .clk   (clk_in),
    .rst_n (rst_n),
    .d     (dcm_status[CLKIN_STOPPED_BIT]),
    .q     (stop_s)
  );

  // Only CLKIN-stopped is acted on; the remaining STATUS bits are informational
  assign status_unused = ^{dcm_status[7:2], dcm_status[0]};

  // Lock loss and CLKIN stop together are a single failure event
  assign lock_lost_s = ~locked_s | stop_s;
  // Both counters saturate instead of wrapping
  assign cnt_inc     = (cnt_r == CNT_FULL) ? cnt_r : (cnt_r + CNT_ONE);
  assign retry_inc   = (retry_r == RETRY_MAX) ? retry_r : (retry_r + 4'd1);

  // Next-state, shared-counter and retry decisions
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_inc;
    retry_nxt = retry_r;
    case (state_r)
      RESET_DCM: begin
        if (cnt_r == RST_LAST) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = CNT_ZERO;
        end else begin
          cnt_nxt   = cnt_inc;
        end
      end
      WAIT_LOCK: begin
        // A lock seen on the timeout cycle still counts as a lock
        if (locked_s) begin
          state_nxt = STABILIZE;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt_r == TIMEOUT_LAST) begin
          state_nxt = (retry_r == RETRY_LAST) ? FAULT : RESET_DCM;
          cnt_nxt   = CNT_ZERO;
          retry_nxt = retry_inc;
        end else begin
          cnt_nxt   = cnt_inc;
        end
      end
      STABILIZE: begin
        if (lock_lost_s) begin
          state_nxt = (retry_r == RETRY_LAST) ? FAULT : RESET_DCM;
          cnt_nxt   = CNT_ZERO;
          retry_nxt = retry_inc;
        end else if (cnt_r == STABLE_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = CNT_ZERO;
          retry_nxt = 4'd0;
        end else begin
          cnt_nxt   = cnt_inc;
        end
      end
      RUN: begin
        // Losing lock after a successful bring-up is not a failed attempt
        cnt_nxt = CNT_ZERO;
        if (lock_lost_s) begin
          state_nxt = RESET_DCM;
        end else begin
          state_nxt = RUN;
        end
      end
      FAULT: begin
        cnt_nxt = CNT_ZERO;
        if (restart) begin
          state_nxt = RESET_DCM;
          retry_nxt = 4'd0;
        end else begin
          state_nxt = FAULT;
        end
      end
      default: begin
        state_nxt = RESET_DCM;
        cnt_nxt   = CNT_ZERO;
        retry_nxt = 4'd0;
      end
    endcase
  end

  // State, counters and outputs registered together; outputs decode the state being entered
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RESET_DCM;
      cnt_r   <= CNT_ZERO;
      retry_r <= 4'd0;
      ctrl_r  <= CTRL_RESET;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      retry_r <= retry_nxt;
      ctrl_r  <= ctrl_for(state_nxt);
    end
  end

  assign dcm_rst   = ctrl_r.dcm_rst;
  assign sys_rst_n = ctrl_r.sys_rst_n;
  assign ready     = ctrl_r.ready;
  assign fault     = ctrl_r.fault;
  assign retry_cnt = retry_r;

endmodule
